// File: rtl/mc14433_conv_ctrl.sv
// MC14433-style dual-slope conversion controller: AZ -> INT -> DEINT -> EOC
// sequencing, 3.5-digit BCD de-integrate counter, display latch and digit scan.
module mc14433_conv_ctrl #(
  parameter int unsigned T_AZ     = 4000,
  parameter int unsigned T_INT    = 2000,
  parameter int unsigned SCAN_DIV = 64
) (
  input  logic        CP0,
  input  logic        R_clock,
  input  logic        CMP,
  input  logic        POL_IN,
  input  logic        DU,
  output logic        AZ,
  output logic        INTEG,
  output logic        DEINT,
  output logic        REF_NEG,
  output logic        EOC,
  output logic [15:0] RESULT,
  output logic        POL,
  output logic        OVR,
  output logic [3:0]  DS,
  output logic [3:0]  Q
);

  typedef enum logic [1:0] {S_AZ, S_INT, S_DEINT, S_EOC} state_t;

  localparam logic [15:0] AZ_LAST   = 16'(T_AZ - 1);
  localparam logic [15:0] INT_LAST  = 16'(T_INT - 1);
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BCD_FULL  = 16'h1999;

  state_t      state_q, state_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] bcd_inc;
  logic        ovr_cond_q, ovr_cond_d;
  logic        pol_reg_q, pol_reg_d;
  logic [15:0] result_q, result_d;
  logic        pol_q, pol_d;
  logic        ovr_q, ovr_d;
  logic [15:0] scan_q, scan_d;
  logic [3:0]  ds_q, ds_d;
  logic        az_q, az_d;
  logic        integ_q, integ_d;
  logic        deint_q, deint_d;
  logic        eoc_q, eoc_d;
  logic [3:0]  q_sel;

  // Decimal increment of the de-integrate count, rippling carry digit by digit.
  always_comb begin
    bcd_inc = bcd_q;
    if (bcd_q[3:0] == 4'd9) begin
      bcd_inc[3:0] = 4'd0;
      if (bcd_q[7:4] == 4'd9) begin
        bcd_inc[7:4] = 4'd0;
        if (bcd_q[11:8] == 4'd9) begin
          bcd_inc[11:8]  = 4'd0;
          bcd_inc[15:12] = bcd_q[15:12] + 4'd1;
        end else begin
          bcd_inc[11:8] = bcd_q[11:8] + 4'd1;
        end
      end else begin
        bcd_inc[7:4] = bcd_q[7:4] + 4'd1;
      end
    end else begin
      bcd_inc[3:0] = bcd_q[3:0] + 4'd1;
    end
  end

  // Next-state logic for the conversion sequence, display latch and digit scan.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bcd_d      = bcd_q;
    ovr_cond_d = ovr_cond_q;
    pol_reg_d  = pol_reg_q;
    result_d   = result_q;
    pol_d      = pol_q;
    ovr_d      = ovr_q;
    scan_d     = scan_q;
    ds_d       = ds_q;

    unique case (state_q)
      S_AZ: begin
        if (phase_q == AZ_LAST) begin
          state_d = S_INT;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_INT: begin
        if (phase_q == INT_LAST) begin
          pol_reg_d  = POL_IN;
          state_d    = S_DEINT;
          phase_d    = '0;
          bcd_d      = '0;
          ovr_cond_d = 1'b0;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end
      S_DEINT: begin
        // A zero crossing beats the full-scale stop when both land together.
        if (!CMP) begin
          state_d = S_EOC;
        end else begin
          bcd_d = bcd_inc;
          if (bcd_inc == BCD_FULL) begin
            ovr_cond_d = 1'b1;
            state_d    = S_EOC;
          end
        end
      end
      S_EOC: begin
        if (DU) begin
          result_d = bcd_q;
          pol_d    = pol_reg_q;
          ovr_d    = ovr_cond_q;
        end
        state_d = S_AZ;
        phase_d = '0;
      end
      default: state_d = S_AZ;
    endcase

    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      ds_d   = {ds_q[2:0], ds_q[3]};
    end else begin
      scan_d = scan_q + 16'd1;
    end

    az_d    = (state_d == S_AZ);
    integ_d = (state_d == S_INT);
    deint_d = (state_d == S_DEINT);
    eoc_d   = (state_d == S_EOC);
  end

  // State, counters and registered phase outputs; reset abandons any conversion.
  always_ff @(posedge CP0 or posedge R_clock) begin
    if (R_clock) begin
      state_q    <= S_AZ;
      phase_q    <= '0;
      bcd_q      <= '0;
      ovr_cond_q <= 1'b0;
      pol_reg_q  <= 1'b0;
      result_q   <= '0;
      pol_q      <= 1'b0;
      ovr_q      <= 1'b0;
      scan_q     <= '0;
      ds_q       <= 4'b0001;
      az_q       <= 1'b1;
      integ_q    <= 1'b0;
      deint_q    <= 1'b0;
      eoc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bcd_q      <= bcd_d;
      ovr_cond_q <= ovr_cond_d;
      pol_reg_q  <= pol_reg_d;
      result_q   <= result_d;
      pol_q      <= pol_d;
      ovr_q      <= ovr_d;
      scan_q     <= scan_d;
      ds_q       <= ds_d;
      az_q       <= az_d;
      integ_q    <= integ_d;
      deint_q    <= deint_d;
      eoc_q      <= eoc_d;
    end
  end

  // Digit multiplexer: DS[0] strobes the half-digit.
  always_comb begin
    q_sel = '0;
    unique case (ds_q)
      4'b0001: q_sel = result_q[15:12];
      4'b0010: q_sel = result_q[11:8];
      4'b0100: q_sel = result_q[7:4];
      4'b1000: q_sel = result_q[3:0];
      default: q_sel = '0;
    endcase
  end

  assign AZ      = az_q;
  assign INTEG   = integ_q;
  assign DEINT   = deint_q;
  assign EOC     = eoc_q;
  assign REF_NEG = pol_reg_q;
  assign RESULT  = result_q;
  assign POL     = pol_q;
  assign OVR     = ovr_q;
  assign DS      = ds_q;
  assign Q       = q_sel;

endmodule

// File: doc/mc14433_conv_ctrl.md
MC14433_CONV_CTRL -- requirements
Module: mc14433_conv_ctrl

Parameters
REQ-001 The block SHALL provide these parameters, one per line: name, default, meaning.
- T_AZ, 4000, auto-zero phase length in CP0 cycles (legal range 1..65535).
- T_INT, 2000, signal-integrate phase length in CP0 cycles (legal range 1..65535).
- SCAN_DIV, 64, CP0 cycles each digit strobe is held (legal range 1..65535).

Interface
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CP0, in, 1, sole clock; all state changes on the rising edge.
- R_clock, in, 1, reset; asynchronous, active-high.
- CMP, in, 1, integrator comparator; 1 = integrator has not yet crossed zero.
- POL_IN, in, 1, input polarity from the comparator; 1 = negative input.
- DU, in, 1, display-update enable, sampled in the EOC state.
- AZ, out, 1, auto-zero phase enable.
- INTEG, out, 1, signal-integrate phase enable.
- DEINT, out, 1, reference de-integrate phase enable.
- REF_NEG, out, 1, reference polarity select during DEINT; equals the latched polarity.
- EOC, out, 1, end-of-conversion pulse; one cycle long.
- RESULT, out, 16, latched 4-digit BCD result; [15:12] is the half-digit (0 or 1).
- POL, out, 1, latched polarity.
- OVR, out, 1, latched overrange flag.
- DS, out, 4, one-hot digit strobe; DS[0] selects the most significant digit.
- Q, out, 4, BCD digit of RESULT selected by DS.

Function
REQ-003 The FSM SHALL have states S_AZ, S_INT, S_DEINT and S_EOC and SHALL run continuously: S_AZ -> S_INT -> S_DEINT -> S_EOC -> S_AZ.
REQ-004 AZ, INTEG and DEINT SHALL be Moore decodes of S_AZ, S_INT and S_DEINT and SHALL be mutually exclusive; in S_EOC all three SHALL be 0.
REQ-005 S_AZ SHALL last exactly T_AZ cycles and S_INT exactly T_INT cycles, timed by one phase counter that clears on every state entry.
REQ-006 POL_IN SHALL be captured into an internal polarity register on the last S_INT cycle; REF_NEG SHALL equal that register.
REQ-007 A 4-digit BCD counter SHALL clear on entry to S_DEINT.
REQ-008 In each S_DEINT cycle with CMP=1, the BCD counter SHALL increment with decimal carry (0009->0010, 0999->1000).
REQ-009 S_DEINT SHALL end when either:
- CMP=0 is sampled; the count is not incremented that cycle and the next state is S_EOC; or
- the count reaches 1999 while CMP=1; the overrange condition is set and the next state is S_EOC.
REQ-010 If CMP=0 on the first S_DEINT cycle, the count SHALL be 0000.
REQ-011 If CMP=0 in the same cycle the count reaches 1999, the comparator SHALL win and overrange SHALL not be set.
REQ-012 S_EOC SHALL last one cycle, with EOC=1 only in that cycle.
REQ-013 In S_EOC with DU=1, RESULT, POL and OVR SHALL load the count, the polarity register and the overrange condition; with DU=0 they SHALL hold their previous values.
REQ-014 CMP and POL_IN SHALL be ignored outside S_DEINT and outside the last S_INT cycle respectively.
REQ-015 DS SHALL rotate 0001 -> 0010 -> 0100 -> 1000 -> 0001, advancing every SCAN_DIV cycles, independent of the FSM.
REQ-016 Q SHALL be RESULT[15:12], [11:8], [7:4] or [3:0] for DS = 0001, 0010, 0100 or 1000 respectively.

Reset
REQ-017 While R_clock=1, the block SHALL immediately force:
- state S_AZ, so AZ=1 and INTEG=DEINT=EOC=0;
- RESULT=16'h0000, POL=0, OVR=0, REF_NEG=0;
- DS=4'b0001, Q=0;
- all counters to 0.
REQ-018 Reset asserted mid-conversion SHALL abandon that conversion without updating RESULT.
REQ-019 After reset release, the first S_AZ SHALL last the full T_AZ cycles.

Verification (T_AZ=4, T_INT=8, SCAN_DIV=2 unless stated)
REQ-020 The bench SHALL cover these directed scenarios:
- Nominal conversion: DU=1, CMP=1 for 5 DEINT cycles then 0 -> AZ for 4 cycles, INTEG for 8, DEINT for 6, then a single EOC pulse; RESULT=16'h0005, OVR=0.
- Overrange: CMP held 1 -> carry 0999->1000 observed; DEINT ends at count 1999; RESULT=16'h1999, OVR=1.
- Display hold: one conversion with DU=1 giving 0005, then a conversion with DU=0 and count 0012 -> EOC pulses both times; RESULT stays 16'h0005.
- Polarity: POL_IN=1 on the last INT cycle, 0 elsewhere -> REF_NEG=1 throughout DEINT; POL=1 after EOC.
- Reset mid-DEINT: R_clock pulsed at count 3 -> AZ=1 asynchronously, RESULT=0; next conversion starts with a full 4-cycle AZ.
- Scan: RESULT=16'h1234 -> DS 0001/0010/0100/1000, each held 2 cycles, with Q=1/2/3/4; then wraps to 0001.
